// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the KGP mini-RISC datapath: FETCH/DECODE/EXEC/MEM/WB sequencing.
// Optional MULTICYCLE_CTRL_DMEM_WAIT_EN: MEM is held until dmem_ready is seen on a clock edge.
module multicycle_ctrl #(
  parameter int ALU_OP_W = 4,
  parameter int BR_OP_W  = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          opcode,
  input  logic [5:0]          func,
  input  logic                dmem_ready,
  output logic                ir_load,
  output logic                pc_update,
  output logic [1:0]          reg_write,
  output logic                imm_mux_ctrl,
  output logic                alu_mux_ctrl,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                dmem_enable,
  output logic                dmem_write_enable,
  output logic [1:0]          reg_write_mux_ctrl,
  output logic [BR_OP_W-1:0]  br_op,
  output logic                busy,
  output logic                illegal,
  output logic [2:0]          state_dbg
);

  typedef enum logic [2:0] {
    RESET_S = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    EXEC    = 3'd3,
    MEM     = 3'd4,
    WB      = 3'd5,
    HALT    = 3'd6
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_I    = 6'b000001;
  localparam logic [5:0] OP_LW   = 6'b000010;
  localparam logic [5:0] OP_SW   = 6'b000011;
  localparam logic [5:0] OP_BR   = 6'b000100;
  localparam logic [5:0] OP_HALT = 6'b111111;

  state_t     state, state_nx;
  logic [5:0] op_q;
  logic [4:0] fn_q;
  logic       live_legal;
  logic       mem_done;
  logic       unused_in;

  // Memory handshake: dmem_enable is a request held with all MEM outputs
  // stable; the access completes on the first rising edge where dmem_ready=1.
`ifdef MULTICYCLE_CTRL_DMEM_WAIT_EN
  assign mem_done  = dmem_ready;
  assign unused_in = func[5];
`else
  assign mem_done  = 1'b1;
  assign unused_in = func[5] ^ dmem_ready;
`endif

  assign live_legal = (opcode == OP_R) || (opcode == OP_I) || (opcode == OP_LW) ||
                      (opcode == OP_SW) || (opcode == OP_BR);
  assign state_dbg  = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RESET_S;
      op_q  <= 6'd0;
      fn_q  <= 5'd0;
    end else begin
      state <= state_nx;
      if (state == DECODE) begin
        op_q <= opcode;
        fn_q <= func[4:0];
      end
    end
  end

  always_comb begin
    state_nx           = state;
    ir_load            = 1'b0;
    pc_update          = 1'b0;
    reg_write          = 2'b00;
    imm_mux_ctrl       = 1'b0;
    alu_mux_ctrl       = 1'b0;
    alu_op             = '0;
    dmem_enable        = 1'b0;
    dmem_write_enable  = 1'b0;
    reg_write_mux_ctrl = 2'b00;
    br_op              = '0;
    illegal            = 1'b0;
    busy               = (state != RESET_S) && (state != HALT);

    // ALU setup is held from EXEC until the instruction retires.
    if ((state == EXEC) || (state == MEM) || (state == WB)) begin
      case (op_q)
        OP_R:         alu_op = fn_q[ALU_OP_W-1:0];
        OP_I: begin
          alu_op       = fn_q[ALU_OP_W-1:0];
          imm_mux_ctrl = 1'b1;
          alu_mux_ctrl = 1'b1;
        end
        OP_LW, OP_SW: begin
          imm_mux_ctrl = 1'b1;
          alu_mux_ctrl = 1'b1;
        end
        default: ;
      endcase
    end

    case (state)
      RESET_S: state_nx = FETCH;
      FETCH: begin
        ir_load  = 1'b1;
        state_nx = DECODE;
      end
      DECODE: begin
        // The opcode is only valid from the freshly loaded IR here, so the
        // illegal trap is the one output decoded from the live inputs.
        if (opcode == OP_HALT) begin
          state_nx = HALT;
        end else if (live_legal) begin
          state_nx = EXEC;
        end else begin
          illegal   = 1'b1;
          pc_update = 1'b1;
          state_nx  = FETCH;
        end
      end
      EXEC: begin
        case (op_q)
          OP_R, OP_I:   state_nx = WB;
          OP_LW, OP_SW: state_nx = MEM;
          default: begin
            br_op     = fn_q[BR_OP_W-1:0];
            pc_update = 1'b1;
            state_nx  = FETCH;
          end
        endcase
      end
      MEM: begin
        dmem_enable       = 1'b1;
        dmem_write_enable = (op_q == OP_SW);
        if (mem_done) begin
          pc_update = (op_q == OP_SW);
          state_nx  = (op_q == OP_SW) ? FETCH : WB;
        end
      end
      WB: begin
        pc_update = 1'b1;
        state_nx  = FETCH;
        if (op_q == OP_LW) begin
          reg_write          = 2'b10;
          reg_write_mux_ctrl = 2'b01;
        end else begin
          reg_write          = 2'b01;
          reg_write_mux_ctrl = 2'b10;
        end
      end
      HALT:    state_nx = HALT;
      default: state_nx = RESET_S;
    endcase
  end

endmodule
